// File: rtl/riscv_irq_unit_pkg.sv
// Shared definitions for the interrupt source unit: config register offsets
// and the config port state encoding.
package riscv_irq_unit_pkg;

  localparam logic [4:0] IRQ_REG_MASK    = 5'h00;
  localparam logic [4:0] IRQ_REG_PENDING = 5'h04;
  localparam logic [4:0] IRQ_REG_SET     = 5'h08;
  localparam logic [4:0] IRQ_REG_CLEAR   = 5'h0C;
  localparam logic [4:0] IRQ_REG_ID      = 5'h10;

  typedef enum logic {
    CFG_IDLE = 1'b0,
    CFG_RESP = 1'b1
  } cfg_state_e;

endpackage

// File: rtl/riscv_irq_unit_prio_enc.sv
// Lowest-index-first priority encoder; matches the core's cause selection order.
module riscv_irq_prio_enc #(
  parameter int N = 32
) (
  input  logic [N-1:0] req_i,
  output logic [4:0]   id_o,
  output logic         valid_o
);

  always_comb begin
    id_o = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req_i[i]) id_o = 5'(i);
    end
  end

  assign valid_o = |req_i;

endmodule

// File: rtl/riscv_irq_unit.sv
// Interrupt source unit: event capture, pending/mask registers, config port.
// Optional RISCV_IRQ_SYNC_EN adds a 2-flop synchronizer on event_i.
//
// state    | meaning
// CFG_IDLE | grant asserted, a request is performed at the next edge
// CFG_RESP | response (rvalid/rdata/err) presented, no grant
module riscv_irq_unit
  import riscv_irq_unit_pkg::*;
#(
  parameter int N_IRQ  = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_IRQ-1:0]  event_i,
  output logic [N_IRQ-1:0]  irq_o,
  output logic [4:0]        irq_id_o,
  output logic              irq_valid_o,
  input  logic              irq_ack_i,
  input  logic [4:0]        irq_ack_id_i,
  input  logic              cfg_req_i,
  input  logic              cfg_we_i,
  input  logic [ADDR_W-1:0] cfg_addr_i,
  input  logic [31:0]       cfg_wdata_i,
  output logic              cfg_gnt_o,
  output logic              cfg_rvalid_o,
  output logic [31:0]       cfg_rdata_o,
  output logic              cfg_err_o
);

  cfg_state_e       state_q;
  logic [N_IRQ-1:0] mask_q;
  logic [N_IRQ-1:0] pending_q;
  logic [N_IRQ-1:0] event_q;
  logic [N_IRQ-1:0] event_s;
  logic [N_IRQ-1:0] rise;
  logic [N_IRQ-1:0] ack_vec;
  logic [N_IRQ-1:0] set_vec;
  logic [N_IRQ-1:0] clr_vec;
  logic [N_IRQ-1:0] wdata;
  logic             access;
  logic             wr_en;
  logic             sel_mask, sel_pend, sel_set, sel_clr, sel_id;
  logic [31:0]      rd_data;
  logic             rd_err;

`ifdef RISCV_IRQ_SYNC_EN
  logic [N_IRQ-1:0] sync1_q;
  logic [N_IRQ-1:0] sync2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= event_i;
      sync2_q <= sync1_q;
    end
  end

  assign event_s = sync2_q;
`else
  assign event_s = event_i;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) event_q <= '0;
    else        event_q <= event_s;
  end

  assign rise  = event_s & ~event_q;
  assign wdata = cfg_wdata_i[N_IRQ-1:0];

  assign access   = cfg_req_i && (state_q == CFG_IDLE);
  assign wr_en    = access && cfg_we_i;
  assign sel_mask = (cfg_addr_i == ADDR_W'(IRQ_REG_MASK));
  assign sel_pend = (cfg_addr_i == ADDR_W'(IRQ_REG_PENDING));
  assign sel_set  = (cfg_addr_i == ADDR_W'(IRQ_REG_SET));
  assign sel_clr  = (cfg_addr_i == ADDR_W'(IRQ_REG_CLEAR));
  assign sel_id   = (cfg_addr_i == ADDR_W'(IRQ_REG_ID));

  // Out-of-range ack ids match no line and so drop out naturally
  always_comb begin
    ack_vec = '0;
    if (irq_ack_i) begin
      for (int i = 0; i < N_IRQ; i++) begin
        if (irq_ack_id_i == 5'(i)) ack_vec[i] = 1'b1;
      end
    end
  end

  assign set_vec = rise
                 | ((wr_en && sel_set)  ? wdata  : '0)
                 | ((wr_en && sel_pend) ? wdata  : '0);
  assign clr_vec = ack_vec
                 | ((wr_en && sel_clr)  ? wdata  : '0)
                 | ((wr_en && sel_pend) ? ~wdata : '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask_q    <= '0;
      pending_q <= '0;
    end else begin
      if (wr_en && sel_mask) mask_q <= wdata;
      pending_q <= (pending_q & ~clr_vec) | set_vec;
    end
  end

  assign irq_o = pending_q & mask_q;

  riscv_irq_prio_enc #(.N(N_IRQ)) u_prio_enc (
    .req_i   (irq_o),
    .id_o    (irq_id_o),
    .valid_o (irq_valid_o)
  );

  always_comb begin
    rd_data = '0;
    rd_err  = 1'b0;
    if      (sel_mask) rd_data = 32'(mask_q);
    else if (sel_pend) rd_data = 32'(pending_q);
    else if (sel_set || sel_clr) rd_data = '0;
    else if (sel_id)   rd_data = {27'b0, irq_id_o};
    else               rd_err  = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= CFG_IDLE;
      cfg_gnt_o    <= 1'b1;
      cfg_rvalid_o <= 1'b0;
      cfg_rdata_o  <= '0;
      cfg_err_o    <= 1'b0;
    end else begin
      case (state_q)
        CFG_IDLE: begin
          if (cfg_req_i) begin
            state_q      <= CFG_RESP;
            cfg_gnt_o    <= 1'b0;
            cfg_rvalid_o <= 1'b1;
            cfg_rdata_o  <= cfg_we_i ? 32'b0 : rd_data;
            cfg_err_o    <= rd_err;
          end
        end
        CFG_RESP: begin
          state_q      <= CFG_IDLE;
          cfg_gnt_o    <= 1'b1;
          cfg_rvalid_o <= 1'b0;
          cfg_rdata_o  <= '0;
          cfg_err_o    <= 1'b0;
        end
        default: begin
          state_q      <= CFG_IDLE;
          cfg_gnt_o    <= 1'b1;
          cfg_rvalid_o <= 1'b0;
          cfg_rdata_o  <= '0;
          cfg_err_o    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_riscv_irq_unit.sv
// Directed bench for riscv_irq_unit; inputs driven and outputs sampled on negedge.
module tb_riscv_irq_unit;

`ifdef RISCV_IRQ_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] event_i = '0;
  logic [31:0] irq_o;
  logic [4:0]  irq_id_o;
  logic        irq_valid_o;
  logic        irq_ack_i = 1'b0;
  logic [4:0]  irq_ack_id_i = '0;
  logic        cfg_req_i = 1'b0;
  logic        cfg_we_i = 1'b0;
  logic [4:0]  cfg_addr_i = '0;
  logic [31:0] cfg_wdata_i = '0;
  logic        cfg_gnt_o;
  logic        cfg_rvalid_o;
  logic [31:0] cfg_rdata_o;
  logic        cfg_err_o;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  riscv_irq_unit #(.N_IRQ(32), .ADDR_W(5)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .event_i      (event_i),
    .irq_o        (irq_o),
    .irq_id_o     (irq_id_o),
    .irq_valid_o  (irq_valid_o),
    .irq_ack_i    (irq_ack_i),
    .irq_ack_id_i (irq_ack_id_i),
    .cfg_req_i    (cfg_req_i),
    .cfg_we_i     (cfg_we_i),
    .cfg_addr_i   (cfg_addr_i),
    .cfg_wdata_i  (cfg_wdata_i),
    .cfg_gnt_o    (cfg_gnt_o),
    .cfg_rvalid_o (cfg_rvalid_o),
    .cfg_rdata_o  (cfg_rdata_o),
    .cfg_err_o    (cfg_err_o)
  );

  // One access: request at a negedge, response sampled one edge later, back to IDLE after another.
  task automatic cfg_access(input logic we, input logic [4:0] addr, input logic [31:0] wdata,
                            output logic [31:0] rdata, output logic err, output logic rv);
    cfg_req_i   = 1'b1;
    cfg_we_i    = we;
    cfg_addr_i  = addr;
    cfg_wdata_i = wdata;
    @(negedge clk);
    rv    = cfg_rvalid_o;
    rdata = cfg_rdata_o;
    err   = cfg_err_o;
    cfg_req_i = 1'b0;
    cfg_we_i  = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    event_i = '0;
    repeat (2) @(negedge clk);
    checks++; if (irq_o !== 32'h0)   begin errors++; $display("FAIL reset_irq: got %h expected %h", irq_o, 32'h0); end
    checks++; if (irq_id_o !== 5'd0) begin errors++; $display("FAIL reset_id: got %0d expected 0", irq_id_o); end
    checks++; if (irq_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", irq_valid_o); end
    checks++; if (cfg_gnt_o !== 1'b1) begin errors++; $display("FAIL reset_gnt: got %b expected 1", cfg_gnt_o); end
    checks++; if ({cfg_rvalid_o, cfg_err_o, cfg_rdata_o} !== 34'h0)
      begin errors++; $display("FAIL reset_resp: got rvalid=%b err=%b rdata=%h expected all 0", cfg_rvalid_o, cfg_err_o, cfg_rdata_o); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    logic [31:0] rd; logic er, rv;
    cfg_access(1'b1, 5'h00, 32'h0000_0005, rd, er, rv);
    event_i[2] = 1'b1;
    #1;
    checks++; if (irq_o !== 32'h0) begin errors++; $display("FAIL basic_pre_edge: got %h expected %h", irq_o, 32'h0); end
    repeat (LAT - 1) @(negedge clk);
    checks++; if (irq_o !== 32'h0) begin errors++; $display("FAIL basic_early: got %h expected %h", irq_o, 32'h0); end
    @(negedge clk);
    checks++; if (irq_o !== 32'h4) begin errors++; $display("FAIL basic_irq: got %h expected %h", irq_o, 32'h4); end
    checks++; if (irq_id_o !== 5'd2) begin errors++; $display("FAIL basic_id: got %0d expected 2", irq_id_o); end
    checks++; if (irq_valid_o !== 1'b1) begin errors++; $display("FAIL basic_valid: got %b expected 1", irq_valid_o); end
    event_i[2] = 1'b0;
    cfg_access(1'b0, 5'h04, 32'h0, rd, er, rv);
    checks++; if (rv !== 1'b1) begin errors++; $display("FAIL basic_rvalid: got %b expected 1", rv); end
    checks++; if (rd !== 32'h4) begin errors++; $display("FAIL basic_rd_pending: got %h expected %h", rd, 32'h4); end
    checks++; if (er !== 1'b0) begin errors++; $display("FAIL basic_err: got %b expected 0", er); end
    cfg_access(1'b1, 5'h04, 32'h0, rd, er, rv);
    repeat (LAT) @(negedge clk);
  endtask

  task automatic test_priority();
    logic [31:0] rd; logic er, rv;
    cfg_access(1'b1, 5'h00, 32'hFFFF_FFFF, rd, er, rv);
    event_i = 32'h88;
    repeat (LAT) @(negedge clk);
    checks++; if (irq_o !== 32'h88) begin errors++; $display("FAIL prio_irq: got %h expected %h", irq_o, 32'h88); end
    checks++; if (irq_id_o !== 5'd3) begin errors++; $display("FAIL prio_id: got %0d expected 3", irq_id_o); end
    event_i = '0;
    irq_ack_i = 1'b1; irq_ack_id_i = 5'd3;
    @(negedge clk);
    irq_ack_i = 1'b0;
    checks++; if (irq_o !== 32'h80) begin errors++; $display("FAIL prio_ack3_irq: got %h expected %h", irq_o, 32'h80); end
    checks++; if (irq_id_o !== 5'd7) begin errors++; $display("FAIL prio_ack3_id: got %0d expected 7", irq_id_o); end
    irq_ack_i = 1'b1; irq_ack_id_i = 5'd7;
    @(negedge clk);
    irq_ack_i = 1'b0;
    checks++; if ({irq_valid_o, irq_o} !== 33'h0) begin errors++; $display("FAIL prio_ack7: got valid=%b irq=%h expected 0", irq_valid_o, irq_o); end
    repeat (LAT) @(negedge clk);
  endtask

  task automatic test_ack_collision();
    event_i[4] = 1'b1;
    repeat (LAT - 1) @(negedge clk);
    irq_ack_i = 1'b1; irq_ack_id_i = 5'd4;
    @(negedge clk);
    irq_ack_i = 1'b0;
    checks++; if (irq_o !== 32'h10) begin errors++; $display("FAIL coll_set_wins: got %h expected %h", irq_o, 32'h10); end
    irq_ack_i = 1'b1; irq_ack_id_i = 5'd4;
    @(negedge clk);
    irq_ack_i = 1'b0;
    checks++; if (irq_o !== 32'h0) begin errors++; $display("FAIL coll_ack_clear: got %h expected %h", irq_o, 32'h0); end
    irq_ack_i = 1'b1; irq_ack_id_i = 5'd4;
    @(negedge clk);
    irq_ack_i = 1'b0;
    checks++; if (irq_o !== 32'h0) begin errors++; $display("FAIL coll_ack_idle: got %h expected %h", irq_o, 32'h0); end
    event_i[4] = 1'b0;
    repeat (LAT) @(negedge clk);
  endtask

  task automatic test_set_clear();
    logic [31:0] rd; logic er, rv;
    cfg_access(1'b1, 5'h00, 32'h0, rd, er, rv);
    cfg_access(1'b1, 5'h08, 32'h10, rd, er, rv);
    checks++; if (irq_o !== 32'h0) begin errors++; $display("FAIL sc_masked: got %h expected %h", irq_o, 32'h0); end
    cfg_access(1'b0, 5'h04, 32'h0, rd, er, rv);
    checks++; if (rd !== 32'h10) begin errors++; $display("FAIL sc_pending: got %h expected %h", rd, 32'h10); end
    cfg_access(1'b0, 5'h08, 32'h0, rd, er, rv);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL sc_set_reads0: got %h expected %h", rd, 32'h0); end
    cfg_access(1'b1, 5'h00, 32'h10, rd, er, rv);
    checks++; if (irq_o !== 32'h10) begin errors++; $display("FAIL sc_unmasked: got %h expected %h", irq_o, 32'h10); end
    cfg_access(1'b0, 5'h10, 32'h0, rd, er, rv);
    checks++; if (rd !== 32'h4) begin errors++; $display("FAIL sc_id_read: got %h expected %h", rd, 32'h4); end
    cfg_access(1'b1, 5'h10, 32'h1F, rd, er, rv);
    checks++; if (er !== 1'b0) begin errors++; $display("FAIL sc_id_write_err: got %b expected 0", er); end
    cfg_access(1'b1, 5'h0C, 32'h10, rd, er, rv);
    checks++; if (irq_o !== 32'h0) begin errors++; $display("FAIL sc_clear: got %h expected %h", irq_o, 32'h0); end
    cfg_access(1'b1, 5'h00, 32'h0F, rd, er, rv);
    cfg_access(1'b1, 5'h04, 32'h6, rd, er, rv);
    checks++; if (irq_o !== 32'h6) begin errors++; $display("FAIL sc_pend_write: got %h expected %h", irq_o, 32'h6); end
    checks++; if (irq_id_o !== 5'd1) begin errors++; $display("FAIL sc_pend_id: got %0d expected 1", irq_id_o); end
    cfg_access(1'b1, 5'h04, 32'h0, rd, er, rv);
    checks++; if (irq_o !== 32'h0) begin errors++; $display("FAIL sc_pend_zero: got %h expected %h", irq_o, 32'h0); end
  endtask

  task automatic test_err_back_to_back();
    logic [31:0] rd; logic er, rv;
    cfg_access(1'b0, 5'h14, 32'h0, rd, er, rv);
    checks++; if (er !== 1'b1) begin errors++; $display("FAIL err_flag: got %b expected 1", er); end
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL err_rdata: got %h expected %h", rd, 32'h0); end
    cfg_req_i = 1'b1; cfg_we_i = 1'b1; cfg_addr_i = 5'h00; cfg_wdata_i = 32'h1;
    @(negedge clk);
    checks++; if ({cfg_gnt_o, cfg_rvalid_o} !== 2'b01) begin errors++; $display("FAIL b2b_resp1: got gnt=%b rvalid=%b expected 0 1", cfg_gnt_o, cfg_rvalid_o); end
    cfg_we_i = 1'b0; cfg_addr_i = 5'h00; cfg_wdata_i = 32'h0;
    @(negedge clk);
    checks++; if ({cfg_gnt_o, cfg_rvalid_o} !== 2'b10) begin errors++; $display("FAIL b2b_idle: got gnt=%b rvalid=%b expected 1 0", cfg_gnt_o, cfg_rvalid_o); end
    @(negedge clk);
    cfg_req_i = 1'b0;
    checks++; if ({cfg_rvalid_o, cfg_rdata_o} !== {1'b1, 32'h1}) begin errors++; $display("FAIL b2b_resp2: got rvalid=%b rdata=%h expected 1 %h", cfg_rvalid_o, cfg_rdata_o, 32'h1); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd; logic er, rv;
    cfg_access(1'b1, 5'h00, 32'hFF, rd, er, rv);
    cfg_access(1'b1, 5'h08, 32'h0F, rd, er, rv);
    cfg_req_i = 1'b1; cfg_we_i = 1'b0; cfg_addr_i = 5'h04;
    @(negedge clk);
    cfg_req_i = 1'b0;
    checks++; if (cfg_rvalid_o !== 1'b1) begin errors++; $display("FAIL rstmid_in_resp: got %b expected 1", cfg_rvalid_o); end
    rst_n = 1'b0;
    #1;
    checks++; if ({cfg_rvalid_o, cfg_gnt_o} !== 2'b01) begin errors++; $display("FAIL rstmid_resp: got rvalid=%b gnt=%b expected 0 1", cfg_rvalid_o, cfg_gnt_o); end
    checks++; if (irq_o !== 32'h0) begin errors++; $display("FAIL rstmid_irq: got %h expected %h", irq_o, 32'h0); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (cfg_rvalid_o !== 1'b0) begin errors++; $display("FAIL rstmid_no_rvalid: got %b expected 0", cfg_rvalid_o); end
    cfg_access(1'b0, 5'h00, 32'h0, rd, er, rv);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL rstmid_mask: got %h expected %h", rd, 32'h0); end
    cfg_access(1'b0, 5'h04, 32'h0, rd, er, rv);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL rstmid_pending: got %h expected %h", rd, 32'h0); end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_basic();
    test_priority();
    test_ack_collision();
    test_set_clear();
    test_err_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
